// File: rtl/board_reveal_engine.sv
// board_reveal_engine: minesweeper reveal/flag command engine over the board RAM; define BOARD_FLOOD_FILL_EN for zero-region flood fill
module board_reveal_engine #(
    parameter int N = 8,
    localparam int AW = $clog2(N*N),
    localparam int RW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_game,
    input  logic [7:0]    bomb_count,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [RW-1:0] cmd_row,
    input  logic [RW-1:0] cmd_col,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [8:0]    mem_rdata,
    output logic          mem_we,
    output logic [8:0]    mem_wdata,
    output logic          done,
    output logic [1:0]    result,
    output logic [6:0]    revealed_count,
    output logic [6:0]    flag_count,
    output logic          game_over,
    output logic          win
);
    typedef enum logic [2:0] {IDLE, FETCH, EVAL, POP, NB_RD, NB_EVAL, FIN, OVER} state_t;
    localparam logic [1:0] RES_OK = 2'd0, RES_IGN = 2'd1, RES_BOMB = 2'd2;
    state_t state_q, state_d;
    logic op_q, op_d, rd_q, rd_d, ready_q, ready_d, done_q, done_d, over_q, over_d, win_q, win_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0] res_q, res_d;
    logic [6:0] rev_q, rev_d, flg_q, flg_d;
    logic [7:0] bombs_q, bombs_d;
    logic we, rv, fl, bm;
    logic [8:0] wdata;
    assign rv = mem_rdata[6];
    assign fl = mem_rdata[7];
    assign bm = mem_rdata[5];
`ifdef BOARD_FLOOD_FILL_EN
    logic [AW-1:0] stk [N*N];
    logic [AW:0] sp_q, sp_d;
    logic [AW-1:0] p_q, p_d, ctr, nb_addr;
    logic [2:0] nb_q, nb_d, nxt;
    logic push, have;
    function automatic int dro(input int i);
        return i < 3 ? -1 : (i < 5 ? 0 : 1);
    endfunction
    function automatic int dco(input int i);
        return (i == 0 || i == 3 || i == 5) ? -1 : ((i == 1 || i == 6) ? 0 : 1);
    endfunction
    // lowest in-board neighbour direction at or after the scan position; off-board ones cost no cycles
    always_comb begin
        int r, c, start;
        ctr = state_q == POP ? stk[sp_q[AW-1:0] - AW'(1)] : p_q;
        r = int'(ctr) / N;
        c = int'(ctr) % N;
        start = state_q == POP ? 0 : int'(nb_q) + 1;
        nxt = '0;
        have = 1'b0;
        for (int i = 7; i >= 0; i--)
            if (i >= start && r + dro(i) >= 0 && r + dro(i) < N && c + dco(i) >= 0 && c + dco(i) < N) begin
                nxt = 3'(i);
                have = 1'b1;
            end
        nb_addr = AW'((r + dro(int'(nxt))) * N + c + dco(int'(nxt)));
    end
    always_ff @(posedge clk)
        if (push) stk[sp_q[AW-1:0]] <= addr_q;
`endif
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        addr_d = addr_q;
        rd_d = 1'b0;
        done_d = 1'b0;
        over_d = over_q;
        win_d = win_q;
        res_d = res_q;
        rev_d = rev_q;
        flg_d = flg_q;
        bombs_d = bombs_q;
        we = 1'b0;
        wdata = '0;
`ifdef BOARD_FLOOD_FILL_EN
        sp_d = sp_q;
        p_d = p_q;
        nb_d = nb_q;
        push = 1'b0;
`endif
        if (new_game && (state_q == IDLE || state_q == OVER)) begin
            state_d = IDLE;
            rev_d = '0;
            flg_d = '0;
            over_d = 1'b0;
            win_d = 1'b0;
            bombs_d = bomb_count;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid && ready_q) begin
                    op_d = cmd_op;
                    addr_d = AW'(int'(cmd_row) * N + int'(cmd_col));
                    rd_d = 1'b1;
                    state_d = FETCH;
                end
                FETCH: state_d = EVAL;
                EVAL: begin
                    state_d = FIN;
                    res_d = RES_IGN;
                    if (op_q && !rv) begin
                        we = 1'b1;
                        wdata = mem_rdata ^ 9'h080;
                        flg_d = fl ? flg_q - 7'd1 : flg_q + 7'd1;
                        res_d = RES_OK;
                    end else if (!op_q && !rv && !fl) begin
                        we = 1'b1;
                        wdata = mem_rdata | 9'h040;
                        over_d = bm;
                        res_d = bm ? RES_BOMB : RES_OK;
                        rev_d = bm ? rev_q : rev_q + 7'd1;
`ifdef BOARD_FLOOD_FILL_EN
                        if (!bm && mem_rdata[3:0] == 4'd0) begin
                            push = 1'b1;
                            sp_d = sp_q + (AW+1)'(1);
                            state_d = POP;
                        end
`endif
                    end
                end
`ifdef BOARD_FLOOD_FILL_EN
                POP: begin
                    sp_d = sp_q - (AW+1)'(1);
                    p_d = ctr;
                    nb_d = nxt;
                    addr_d = have ? nb_addr : addr_q;
                    rd_d = have;
                    state_d = have ? NB_RD : (sp_d != '0 ? POP : FIN);
                end
                NB_RD: state_d = NB_EVAL;
                NB_EVAL: begin
                    if (!rv && !fl && !bm) begin
                        we = 1'b1;
                        wdata = mem_rdata | 9'h040;
                        rev_d = rev_q + 7'd1;
                        push = mem_rdata[3:0] == 4'd0;
                        sp_d = push ? sp_q + (AW+1)'(1) : sp_q;
                    end
                    nb_d = nxt;
                    addr_d = have ? nb_addr : addr_q;
                    rd_d = have;
                    state_d = have ? NB_RD : (sp_d != '0 ? POP : FIN);
                end
`endif
                FIN: state_d = (over_q || win_q) ? OVER : IDLE;
                OVER: state_d = OVER;
                default: state_d = IDLE;
            endcase
        end
        if (state_d == FIN) begin
            done_d = 1'b1;
            win_d = win_q | (!over_d && {1'b0, rev_d} == 8'(N*N) - bombs_q);
        end
        ready_d = state_d == IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q <= 1'b0;
            addr_q <= '0;
            rd_q <= 1'b0;
            ready_q <= 1'b0;
            done_q <= 1'b0;
            over_q <= 1'b0;
            win_q <= 1'b0;
            res_q <= '0;
            rev_q <= '0;
            flg_q <= '0;
            bombs_q <= '0;
`ifdef BOARD_FLOOD_FILL_EN
            sp_q <= '0;
            p_q <= '0;
            nb_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            addr_q <= addr_d;
            rd_q <= rd_d;
            ready_q <= ready_d;
            done_q <= done_d;
            over_q <= over_d;
            win_q <= win_d;
            res_q <= res_d;
            rev_q <= rev_d;
            flg_q <= flg_d;
            bombs_q <= bombs_d;
`ifdef BOARD_FLOOD_FILL_EN
            sp_q <= sp_d;
            p_q <= p_d;
            nb_q <= nb_d;
`endif
        end
    end
    assign cmd_ready = ready_q;
    assign mem_addr = addr_q;
    assign mem_rd = rd_q;
    assign mem_we = we;
    assign mem_wdata = wdata;
    assign done = done_q;
    assign result = res_q;
    assign revealed_count = rev_q;
    assign flag_count = flg_q;
    assign game_over = over_q;
    assign win = win_q;
endmodule

// File: tb/tb_board_reveal_engine.sv
// tb_board_reveal_engine: directed vectors against a behavioural board RAM
module tb_board_reveal_engine;
    logic clk = 0, rst = 1, new_game = 0, cmd_valid = 0, cmd_op = 0;
    logic [7:0] bomb_count = 0;
    logic [2:0] cmd_row = 0, cmd_col = 0;
    logic [5:0] mem_addr;
    logic mem_rd, mem_we, done, cmd_ready, game_over, win;
    logic [8:0] mem_rdata = 0, mem_wdata;
    logic [1:0] result;
    logic [6:0] revealed_count, flag_count;
    board_reveal_engine dut (
        .clk(clk), .rst(rst), .new_game(new_game), .bomb_count(bomb_count),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata), .done(done),
        .result(result), .revealed_count(revealed_count), .flag_count(flag_count),
        .game_over(game_over), .win(win)
    );
    always #5 clk = ~clk;

    logic [8:0] ram [64];
    logic fill_en = 0, pl_en = 0;
    logic [8:0] pl_data = 0;
    logic [5:0] pl_addr = 0;
    int n_rd = 0, n_wr = 0, n_both = 0;
    logic [5:0] last_wa = 0;
    logic [8:0] last_wd = 0;
    always @(posedge clk) begin
        if (fill_en) for (int i = 0; i < 64; i++) ram[i] <= pl_data;
        if (pl_en) ram[pl_addr] <= pl_data;
        if (mem_rd) begin
            mem_rdata <= ram[mem_addr];
            n_rd <= n_rd + 1;
        end
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            n_wr <= n_wr + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
        if (mem_rd && mem_we) n_both <= n_both + 1;
    end

    int total = 0, bad = 0;
    int lat, drd, dwr, rd0, wr0;
    logic [1:0] res_s;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic fill(input logic [8:0] d);
        @(negedge clk); pl_data = d; fill_en = 1;
        @(negedge clk); fill_en = 0;
    endtask
    task automatic poke(input int a, input logic [8:0] d);
        @(negedge clk); pl_addr = 6'(a); pl_data = d; pl_en = 1;
        @(negedge clk); pl_en = 0;
    endtask
    task automatic ng(input logic [7:0] b);
        @(negedge clk); new_game = 1; bomb_count = b;
        @(negedge clk); new_game = 0;
    endtask
    task automatic do_cmd(input logic op, input int r, input int c);
        @(negedge clk);
        rd0 = n_rd; wr0 = n_wr;
        cmd_valid = 1; cmd_op = op; cmd_row = 3'(r); cmd_col = 3'(c);
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        while (!done && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", done, 1);
        res_s = result;
        drd = n_rd - rd0;
        dwr = n_wr - wr0;
    endtask

    typedef struct {
        logic op; int r; int c; logic [1:0] res; int wr; logic [8:0] wd; int rev; int flg;
    } vec_t;
    vec_t tv [9];

    initial begin
        tv[0] = '{1'b0, 2, 3, 2'd0, 1, 9'h042, 1, 0};
        tv[1] = '{1'b0, 2, 3, 2'd1, 0, 9'h000, 1, 0};
        tv[2] = '{1'b1, 2, 3, 2'd1, 0, 9'h000, 1, 0};
        tv[3] = '{1'b1, 5, 5, 2'd0, 1, 9'h081, 1, 1};
        tv[4] = '{1'b0, 5, 5, 2'd1, 0, 9'h000, 1, 1};
        tv[5] = '{1'b1, 5, 5, 2'd0, 1, 9'h001, 1, 0};
        tv[6] = '{1'b0, 1, 6, 2'd0, 1, 9'h153, 2, 0};
        tv[7] = '{1'b1, 4, 0, 2'd0, 1, 9'h098, 2, 1};
        tv[8] = '{1'b1, 4, 0, 2'd0, 1, 9'h018, 2, 0};

        repeat (2) @(negedge clk);
        chk("reset_outs", {mem_rd, mem_we, done, game_over, win, result, mem_addr, mem_wdata}, 0);
        chk("reset_counts", {revealed_count, flag_count}, 0);
        chk("reset_ready", cmd_ready, 0);
        rst = 0;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        fill(9'h001);
        poke(19, 9'h002);
        poke(14, 9'h113);
        poke(32, 9'h018);
        ng(8'd10);
        for (int i = 0; i < 9; i++) begin
            do_cmd(tv[i].op, tv[i].r, tv[i].c);
            chk($sformatf("v%0d_lat", i), lat, 3);
            chk($sformatf("v%0d_result", i), res_s, tv[i].res);
            chk($sformatf("v%0d_writes", i), dwr, tv[i].wr);
            chk($sformatf("v%0d_reads", i), drd, 1);
            if (tv[i].wr != 0) begin
                chk($sformatf("v%0d_waddr", i), last_wa, tv[i].r * 8 + tv[i].c);
                chk($sformatf("v%0d_wdata", i), last_wd, tv[i].wd);
            end
            chk($sformatf("v%0d_revealed", i), revealed_count, tv[i].rev);
            chk($sformatf("v%0d_flags", i), flag_count, tv[i].flg);
            chk($sformatf("v%0d_over", i), {game_over, win}, 0);
        end

        poke(0, 9'h020);
        do_cmd(0, 0, 0);
        chk("bomb_lat", lat, 3);
        chk("bomb_result", res_s, 2);
        chk("bomb_wdata", last_wd, 9'h060);
        chk("bomb_waddr", last_wa, 0);
        chk("bomb_over", game_over, 1);
        chk("bomb_nowin", win, 0);
        chk("bomb_revealed", revealed_count, 2);
        rd0 = n_rd;
        @(negedge clk); cmd_valid = 1; cmd_op = 0; cmd_row = 3; cmd_col = 3;
        repeat (4) begin
            @(negedge clk);
            chk("over_not_ready", cmd_ready, 0);
        end
        cmd_valid = 0;
        chk("over_no_accept", n_rd - rd0, 0);
        ng(8'd60);
        chk("ng_ready", cmd_ready, 1);
        chk("ng_clear", {game_over, win, revealed_count, flag_count}, 0);

        rd0 = n_rd;
        @(negedge clk); new_game = 1; bomb_count = 62; cmd_valid = 1; cmd_op = 0; cmd_row = 3; cmd_col = 3;
        @(negedge clk); new_game = 0; cmd_valid = 0;
        repeat (4) @(negedge clk);
        chk("ng_wins_over_cmd", n_rd - rd0, 0);
        chk("ng_coincident_ready", cmd_ready, 1);

        do_cmd(0, 3, 3);
        chk("win1_rev", revealed_count, 1);
        chk("win1_nowin", win, 0);
        do_cmd(0, 3, 4);
        chk("win2_rev", revealed_count, 2);
        chk("win2_result", res_s, 0);
        @(negedge clk);
        chk("win_set", win, 1);
        chk("win_not_ready", cmd_ready, 0);
        chk("win_no_gameover", game_over, 0);

        ng(8'd0);
        fill(9'h001);
        poke(63, 9'h000);
        do_cmd(0, 7, 7);
        chk("corner_self", ram[63], 9'h040);
        chk("corner_far_untouched", ram[53], 9'h001);
`ifdef BOARD_FLOOD_FILL_EN
        chk("corner_lat", lat, 10);
        chk("corner_reads", drd, 4);
        chk("corner_writes", dwr, 4);
        chk("corner_rev", revealed_count, 4);
        chk("corner_nb", {ram[54], ram[55], ram[62]}, {9'h041, 9'h041, 9'h041});

        ng(8'd0);
        fill(9'h000);
        do_cmd(0, 0, 0);
        chk("flood_lat", lat, 907);
        chk("flood_reads", drd, 421);
        chk("flood_rev", revealed_count, 64);
        begin
            int nrev = 0;
            for (int i = 0; i < 64; i++) if (ram[i] == 9'h040) nrev++;
            chk("flood_all_cells", nrev, 64);
        end
        @(negedge clk);
        chk("flood_win", win, 1);
`else
        chk("corner_lat", lat, 3);
        chk("corner_reads", drd, 1);
        chk("corner_writes", dwr, 1);
        chk("corner_rev", revealed_count, 1);
        chk("corner_nb", {ram[54], ram[55], ram[62]}, {9'h001, 9'h001, 9'h001});
`endif

        ng(8'd0);
        fill(9'h000);
        @(negedge clk); cmd_valid = 1; cmd_op = 0; cmd_row = 0; cmd_col = 0;
        @(negedge clk); cmd_valid = 0;
`ifdef BOARD_FLOOD_FILL_EN
        repeat (30) @(negedge clk);
        chk("flood_progress", revealed_count != 0, 1);
`else
        chk("rd_before_rst", mem_rd, 1);
`endif
        chk("busy_before_rst", cmd_ready, 0);
        #2 rst = 1;
        #1;
        chk("rst_outs", {mem_rd, mem_we, done, game_over, win, result, mem_addr, mem_wdata}, 0);
        chk("rst_counts", {revealed_count, flag_count}, 0);
        chk("rst_ready", cmd_ready, 0);
        @(negedge clk); rst = 0;
        @(negedge clk);
        chk("rst_release_ready", cmd_ready, 1);
        chk("rd_we_exclusive", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
